// File: rtl/opendap_ap_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : opendap_ap_access_ctrl
// Brief    : Holds DP-issued AP accesses on a req/ack bus, owns RDBUFF and
//            reports AP errors, timeouts and dropped strobes to the DP.
// Revision : 1.0
// ============================================================================
module opendap_ap_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int W_TIMEOUT      = 8
) (
    input  logic        swclk,
    input  logic        rst,
    input  logic        dp_ap_en,
    input  logic        dp_ap_r_nw,
    input  logic [1:0]  dp_ap_addr,
    input  logic [31:0] dp_ap_wdata,
    input  logic [7:0]  dp_apsel,
    input  logic [3:0]  dp_apbanksel,
    input  logic        dp_ap_abort,
    output logic        ap_rdy,
    output logic [31:0] ap_rdata,
    output logic        dp_set_stickyerr,
    output logic        dp_ap_dropped,
    output logic        ap_req,
    output logic [7:0]  ap_sel,
    output logic [5:0]  ap_addr,
    output logic        ap_r_nw,
    output logic [31:0] ap_wdata,
    input  logic        ap_ack,
    input  logic        ap_err,
    input  logic [31:0] ap_rdata_in
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [W_TIMEOUT-1:0] c_TIMEOUT    = W_TIMEOUT'(TIMEOUT_CYCLES);
    localparam logic [W_TIMEOUT-1:0] c_TIMEOUT_M1 = W_TIMEOUT'(TIMEOUT_CYCLES - 1);
    localparam logic [W_TIMEOUT-1:0] c_ONE        = W_TIMEOUT'(1);

    state_t               r_state;
    logic [W_TIMEOUT-1:0] r_tcnt;
    logic                 r_discard;
    logic                 r_tflag;

    logic w_busy;
    logic w_discard;
    logic w_to_hit;
    logic w_err_report;

    // An abort arriving together with the ack still discards that result.
    always_comb begin
        w_busy       = (r_state == BUSY);
        w_discard    = r_discard | dp_ap_abort;
        w_to_hit     = w_busy && !r_tflag && (r_tcnt == c_TIMEOUT_M1);
        w_err_report = ap_ack && ap_err && !w_discard;
    end

    always_ff @(posedge swclk) begin
        if (rst) begin
            r_state          <= IDLE;
            r_tcnt           <= '0;
            r_discard        <= 1'b0;
            r_tflag          <= 1'b0;
            ap_req           <= 1'b0;
            ap_rdy           <= 1'b1;
            ap_rdata         <= '0;
            dp_set_stickyerr <= 1'b0;
            dp_ap_dropped    <= 1'b0;
            ap_sel           <= '0;
            ap_addr          <= '0;
            ap_r_nw          <= 1'b0;
            ap_wdata         <= '0;
        end else begin
            dp_set_stickyerr <= 1'b0;
            dp_ap_dropped    <= 1'b0;
            if (!w_busy) begin
                if (dp_ap_en) begin
                    r_state  <= BUSY;
                    ap_req   <= 1'b1;
                    ap_rdy   <= 1'b0;
                    ap_r_nw  <= dp_ap_r_nw;
                    ap_sel   <= dp_apsel;
                    ap_addr  <= {dp_apbanksel, dp_ap_addr};
                    ap_wdata <= dp_ap_wdata;
                end
            end else begin
                if (dp_ap_en) begin
                    dp_ap_dropped <= 1'b1;
                end
                if (ap_ack) begin
                    r_state          <= IDLE;
                    ap_req           <= 1'b0;
                    ap_rdy           <= 1'b1;
                    dp_set_stickyerr <= w_err_report | w_to_hit;
                    if (ap_r_nw && !ap_err && !w_discard) begin
                        ap_rdata <= ap_rdata_in;
                    end
                    r_tcnt    <= '0;
                    r_discard <= 1'b0;
                    r_tflag   <= 1'b0;
                end else begin
                    if (r_tcnt != c_TIMEOUT) begin
                        r_tcnt <= r_tcnt + c_ONE;
                    end
                    if (w_to_hit) begin
                        dp_set_stickyerr <= 1'b1;
                        r_tflag          <= 1'b1;
                    end
                    if (dp_ap_abort) begin
                        r_discard <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_opendap_ap_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_opendap_ap_access_ctrl
// Brief    : Scenario bench for the AP access controller with a result scoreboard.
// Revision : 1.0
// ============================================================================
module tb_opendap_ap_access_ctrl;

    logic        swclk = 1'b0;
    logic        rst = 1'b1;
    logic        dp_ap_en = 1'b0;
    logic        dp_ap_r_nw = 1'b0;
    logic [1:0]  dp_ap_addr = '0;
    logic [31:0] dp_ap_wdata = '0;
    logic [7:0]  dp_apsel = '0;
    logic [3:0]  dp_apbanksel = '0;
    logic        dp_ap_abort = 1'b0;
    logic        ap_rdy;
    logic [31:0] ap_rdata;
    logic        dp_set_stickyerr;
    logic        dp_ap_dropped;
    logic        ap_req;
    logic [7:0]  ap_sel;
    logic [5:0]  ap_addr;
    logic        ap_r_nw;
    logic [31:0] ap_wdata;
    logic        ap_ack = 1'b0;
    logic        ap_err = 1'b0;
    logic [31:0] ap_rdata_in = '0;

    opendap_ap_access_ctrl #(
        .TIMEOUT_CYCLES(4),
        .W_TIMEOUT     (8)
    ) u_dut (
        .swclk           (swclk),
        .rst             (rst),
        .dp_ap_en        (dp_ap_en),
        .dp_ap_r_nw      (dp_ap_r_nw),
        .dp_ap_addr      (dp_ap_addr),
        .dp_ap_wdata     (dp_ap_wdata),
        .dp_apsel        (dp_apsel),
        .dp_apbanksel    (dp_apbanksel),
        .dp_ap_abort     (dp_ap_abort),
        .ap_rdy          (ap_rdy),
        .ap_rdata        (ap_rdata),
        .dp_set_stickyerr(dp_set_stickyerr),
        .dp_ap_dropped   (dp_ap_dropped),
        .ap_req          (ap_req),
        .ap_sel          (ap_sel),
        .ap_addr         (ap_addr),
        .ap_r_nw         (ap_r_nw),
        .ap_wdata        (ap_wdata),
        .ap_ack          (ap_ack),
        .ap_err          (ap_err),
        .ap_rdata_in     (ap_rdata_in)
    );

    always #5 swclk = ~swclk;

    typedef struct packed {
        logic        r_nw;
        logic [7:0]  sel;
        logic [5:0]  addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        sticky;
    } res_t;

    req_t        req_q[$];
    res_t        res_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] m_rdata = '0;
    logic        m_rnw = 1'b0;
    logic        m_discard = 1'b0;

    task automatic tick();
        @(posedge swclk);
        #1;
    endtask

    // One-cycle strobe; the expected downstream request is queued alongside.
    task automatic strobe(input logic r_nw, input logic [7:0] sel, input logic [3:0] bank,
                          input logic [1:0] addr, input logic [31:0] wdata);
        dp_ap_en     = 1'b1;
        dp_ap_r_nw   = r_nw;
        dp_apsel     = sel;
        dp_apbanksel = bank;
        dp_ap_addr   = addr;
        dp_ap_wdata  = wdata;
        req_q.push_back({r_nw, sel, bank, addr, wdata});
        m_rnw     = r_nw;
        m_discard = 1'b0;
        tick();
        dp_ap_en = 1'b0;
    endtask

    // Ack for one cycle; the model decides what RDBUFF and STICKYERR must show.
    task automatic do_ack(input logic err, input logic [31:0] rdata, input logic abort);
        logic disc;
        disc        = m_discard | abort;
        ap_ack      = 1'b1;
        ap_err      = err;
        ap_rdata_in = rdata;
        dp_ap_abort = abort;
        if (m_rnw && !err && !disc) m_rdata = rdata;
        res_q.push_back({m_rdata, err && !disc});
        tick();
        ap_ack      = 1'b0;
        ap_err      = 1'b0;
        dp_ap_abort = 1'b0;
        m_discard   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++; if ({ap_req, ap_rdy} !== 2'b01) $display("FAIL reset_hs: got %b want 01", {ap_req, ap_rdy}); else n_pass++;
        n_checks++; if (ap_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", ap_rdata); else n_pass++;
        n_checks++; if ({dp_set_stickyerr, dp_ap_dropped} !== 2'b00) $display("FAIL reset_pulses: got %b want 00", {dp_set_stickyerr, dp_ap_dropped}); else n_pass++;
        n_checks++; if ({ap_r_nw, ap_sel, ap_addr, ap_wdata} !== 47'h0) $display("FAIL reset_fields: got %h want 0", {ap_r_nw, ap_sel, ap_addr, ap_wdata}); else n_pass++;
    endtask

    task automatic test_read();
        req_t e;
        res_t r;
        strobe(1'b1, 8'h02, 4'hF, 2'd3, 32'h0);
        e = req_q.pop_front();
        n_checks++; if ({ap_req, ap_rdy} !== 2'b10) $display("FAIL read_issue: got %b want 10", {ap_req, ap_rdy}); else n_pass++;
        n_checks++; if (ap_addr !== 6'h3F) $display("FAIL read_addr: got %h want 3f", ap_addr); else n_pass++;
        n_checks++; if ({ap_r_nw, ap_sel, ap_addr, ap_wdata} !== e) $display("FAIL read_fields: got %h want %h", {ap_r_nw, ap_sel, ap_addr, ap_wdata}, e); else n_pass++;
        tick();
        tick();
        n_checks++; if (ap_req !== 1'b1) $display("FAIL read_hold: got %b want 1", ap_req); else n_pass++;
        do_ack(1'b0, 32'h12345678, 1'b0);
        r = res_q.pop_front();
        n_checks++; if ({ap_req, ap_rdy} !== 2'b01) $display("FAIL read_done: got %b want 01", {ap_req, ap_rdy}); else n_pass++;
        n_checks++; if (ap_rdata !== r.rdata) $display("FAIL read_rdata: got %h want %h", ap_rdata, r.rdata); else n_pass++;
        n_checks++; if (dp_set_stickyerr !== r.sticky) $display("FAIL read_sticky: got %b want %b", dp_set_stickyerr, r.sticky); else n_pass++;
    endtask

    task automatic test_write_err();
        req_t e;
        res_t r;
        strobe(1'b0, 8'h05, 4'h1, 2'd2, 32'hDEADBEEF);
        e = req_q.pop_front();
        n_checks++; if ({ap_r_nw, ap_sel, ap_addr, ap_wdata} !== e) $display("FAIL wr_fields: got %h want %h", {ap_r_nw, ap_sel, ap_addr, ap_wdata}, e); else n_pass++;
        tick();
        do_ack(1'b1, 32'hFFFFFFFF, 1'b0);
        r = res_q.pop_front();
        n_checks++; if (dp_set_stickyerr !== r.sticky) $display("FAIL wr_err_pulse: got %b want %b", dp_set_stickyerr, r.sticky); else n_pass++;
        n_checks++; if (ap_rdata !== r.rdata) $display("FAIL wr_rdata: got %h want %h", ap_rdata, r.rdata); else n_pass++;
        n_checks++; if (ap_rdy !== 1'b1) $display("FAIL wr_rdy: got %b want 1", ap_rdy); else n_pass++;
        tick();
        n_checks++; if (dp_set_stickyerr !== 1'b0) $display("FAIL wr_err_width: got %b want 0", dp_set_stickyerr); else n_pass++;
    endtask

    task automatic test_abort();
        req_t e;
        res_t r;
        strobe(1'b1, 8'h03, 4'h0, 2'd1, 32'h0);
        e = req_q.pop_front();
        tick();
        dp_ap_abort = 1'b1;
        m_discard   = 1'b1;
        tick();
        dp_ap_abort = 1'b0;
        n_checks++; if (ap_req !== 1'b1) $display("FAIL abort_hold: got %b want 1", ap_req); else n_pass++;
        do_ack(1'b1, 32'h11111111, 1'b0);
        r = res_q.pop_front();
        n_checks++; if ({ap_rdata, dp_set_stickyerr} !== r) $display("FAIL abort_result: got %h/%b want %h/%b", ap_rdata, dp_set_stickyerr, r.rdata, r.sticky); else n_pass++;
        n_checks++; if (ap_rdata !== 32'h12345678) $display("FAIL abort_rdbuff: got %h want 12345678", ap_rdata); else n_pass++;
        n_checks++; if (ap_rdy !== 1'b1) $display("FAIL abort_rdy: got %b want 1", ap_rdy); else n_pass++;

        strobe(1'b1, 8'h03, 4'h0, 2'd1, 32'h0);
        e = req_q.pop_front();
        tick();
        do_ack(1'b1, 32'h11111111, 1'b1);
        r = res_q.pop_front();
        n_checks++; if ({ap_rdata, dp_set_stickyerr} !== r) $display("FAIL abort_same_cycle: got %h/%b want %h/%b", ap_rdata, dp_set_stickyerr, r.rdata, r.sticky); else n_pass++;
        n_checks++; if (ap_rdy !== 1'b1) $display("FAIL abort_same_rdy: got %b want 1", ap_rdy); else n_pass++;

        dp_ap_abort = 1'b1;
        tick();
        dp_ap_abort = 1'b0;
        n_checks++; if ({ap_req, ap_rdy} !== 2'b01) $display("FAIL abort_idle: got %b want 01", {ap_req, ap_rdy}); else n_pass++;
        strobe(1'b1, 8'h04, 4'h2, 2'd0, 32'h0);
        e = req_q.pop_front();
        tick();
        do_ack(1'b0, 32'h5A5A0F0F, 1'b0);
        r = res_q.pop_front();
        n_checks++; if (ap_rdata !== r.rdata) $display("FAIL abort_idle_read: got %h want %h", ap_rdata, r.rdata); else n_pass++;
    endtask

    task automatic test_overlap();
        req_t e;
        res_t r;
        strobe(1'b0, 8'h07, 4'h2, 2'd1, 32'hCAFEF00D);
        e = req_q.pop_front();
        dp_ap_en     = 1'b1;
        dp_ap_r_nw   = 1'b1;
        dp_apsel     = 8'hEE;
        dp_apbanksel = 4'hA;
        dp_ap_addr   = 2'd2;
        dp_ap_wdata  = 32'h55555555;
        tick();
        dp_ap_en = 1'b0;
        n_checks++; if (dp_ap_dropped !== 1'b1) $display("FAIL ovl_dropped: got %b want 1", dp_ap_dropped); else n_pass++;
        n_checks++; if ({ap_r_nw, ap_sel, ap_addr, ap_wdata} !== e) $display("FAIL ovl_fields: got %h want %h", {ap_r_nw, ap_sel, ap_addr, ap_wdata}, e); else n_pass++;
        tick();
        n_checks++; if ({ap_req, dp_ap_dropped} !== 2'b10) $display("FAIL ovl_busy: got %b want 10", {ap_req, dp_ap_dropped}); else n_pass++;
        dp_ap_en = 1'b1;
        do_ack(1'b0, 32'h0, 1'b0);
        dp_ap_en = 1'b0;
        r = res_q.pop_front();
        n_checks++; if ({ap_req, dp_ap_dropped} !== 2'b01) $display("FAIL ovl_ack_drop: got %b want 01", {ap_req, dp_ap_dropped}); else n_pass++;
        n_checks++; if (ap_rdata !== r.rdata) $display("FAIL ovl_rdata: got %h want %h", ap_rdata, r.rdata); else n_pass++;
        tick();
        n_checks++; if ({ap_req, ap_rdy} !== 2'b01) $display("FAIL ovl_single_req: got %b want 01", {ap_req, ap_rdy}); else n_pass++;
    endtask

    task automatic test_back_to_back();
        req_t e;
        res_t r;
        strobe(1'b0, 8'h09, 4'h3, 2'd2, 32'h01020304);
        e = req_q.pop_front();
        tick();
        do_ack(1'b0, 32'h0, 1'b0);
        r = res_q.pop_front();
        n_checks++; if ({ap_req, ap_rdy} !== 2'b01) $display("FAIL b2b_first_done: got %b want 01", {ap_req, ap_rdy}); else n_pass++;
        strobe(1'b1, 8'h0A, 4'h4, 2'd0, 32'h0);
        e = req_q.pop_front();
        n_checks++; if ({ap_req, ap_rdy} !== 2'b10) $display("FAIL b2b_accept: got %b want 10", {ap_req, ap_rdy}); else n_pass++;
        n_checks++; if ({ap_r_nw, ap_sel, ap_addr, ap_wdata} !== e) $display("FAIL b2b_fields: got %h want %h", {ap_r_nw, ap_sel, ap_addr, ap_wdata}, e); else n_pass++;
        tick();
        do_ack(1'b0, 32'h0BADF00D, 1'b0);
        r = res_q.pop_front();
        n_checks++; if (ap_rdata !== r.rdata) $display("FAIL b2b_rdata: got %h want %h", ap_rdata, r.rdata); else n_pass++;
    endtask

    task automatic test_timeout();
        req_t e;
        res_t r;
        int   pulses;
        int   pos;
        logic held;
        pulses = 0;
        pos    = 0;
        held   = 1'b1;
        strobe(1'b1, 8'h01, 4'h0, 2'd0, 32'h0);
        e = req_q.pop_front();
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (dp_set_stickyerr === 1'b1) begin
                pulses++;
                if (pos == 0) pos = i;
            end
            if (ap_req !== 1'b1) held = 1'b0;
        end
        n_checks++; if (pulses != 1) $display("FAIL to_pulse_count: got %0d want 1", pulses); else n_pass++;
        n_checks++; if (pos != 4) $display("FAIL to_pulse_cycle: got %0d want 4", pos); else n_pass++;
        n_checks++; if (held !== 1'b1) $display("FAIL to_req_held: got %b want 1", held); else n_pass++;
        do_ack(1'b0, 32'hAAAA5555, 1'b0);
        r = res_q.pop_front();
        n_checks++; if ({ap_rdata, dp_set_stickyerr} !== r) $display("FAIL to_late_ack: got %h/%b want %h/%b", ap_rdata, dp_set_stickyerr, r.rdata, r.sticky); else n_pass++;
        n_checks++; if (ap_rdy !== 1'b1) $display("FAIL to_rdy: got %b want 1", ap_rdy); else n_pass++;
    endtask

    task automatic test_mid_reset();
        req_t e;
        res_t r;
        strobe(1'b1, 8'h06, 4'h5, 2'd3, 32'h0);
        e = req_q.pop_front();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_rdata = 32'h0;
        n_checks++; if ({ap_req, ap_rdy} !== 2'b01) $display("FAIL mrst_hs: got %b want 01", {ap_req, ap_rdy}); else n_pass++;
        n_checks++; if (ap_rdata !== m_rdata) $display("FAIL mrst_rdata: got %h want %h", ap_rdata, m_rdata); else n_pass++;
        strobe(1'b0, 8'h08, 4'h6, 2'd1, 32'h87654321);
        e = req_q.pop_front();
        n_checks++; if ({ap_req, ap_r_nw, ap_sel, ap_addr, ap_wdata} !== {1'b1, e}) $display("FAIL mrst_accept: got %h want %h", {ap_req, ap_r_nw, ap_sel, ap_addr, ap_wdata}, {1'b1, e}); else n_pass++;
        tick();
        do_ack(1'b0, 32'h0, 1'b0);
        r = res_q.pop_front();
        n_checks++; if ({ap_rdy, ap_rdata} !== {1'b1, r.rdata}) $display("FAIL mrst_done: got %h want %h", {ap_rdy, ap_rdata}, {1'b1, r.rdata}); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read();
        test_write_err();
        test_abort();
        test_overlap();
        test_back_to_back();
        test_timeout();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/opendap_ap_access_ctrl.md
Name: opendap_ap_access_ctrl

Overview:
- Sequences AP accesses on behalf of the SW-DP core.
- Accepts a single-cycle AP access strobe from the DP and holds the access on a downstream request/acknowledge AP bus until it completes.
- Generates ap_rdy, which the serial comms block uses for WAIT decisions.
- Keeps the read buffer (RDBUFF) that supplies posted AP read data, and reports AP errors, timeouts and aborts to the DP sticky logic.

Parameters:
- TIMEOUT_CYCLES, 255: cycles an outstanding access may wait for ap_ack before a timeout is flagged. Legal range 1 to 2**W_TIMEOUT-1.
- W_TIMEOUT, 8: width of the timeout counter.

Ports:
- swclk  in  1  DP clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- dp_ap_en  in  1  single-cycle AP access strobe from the DP.
- dp_ap_r_nw  in  1  1 = read, 0 = write; valid with dp_ap_en.
- dp_ap_addr  in  2  A[3:2] from the packet header.
- dp_ap_wdata  in  32  write data; valid with dp_ap_en.
- dp_apsel  in  8  SELECT.APSEL.
- dp_apbanksel  in  4  SELECT.APBANKSEL.
- dp_ap_abort  in  1  DAPABORT pulse from an ABORT register write.
- ap_rdy  out  1  high when no access is outstanding.
- ap_rdata  out  32  RDBUFF contents.
- dp_set_stickyerr  out  1  single-cycle pulse that sets CTRL/STAT.STICKYERR.
- dp_ap_dropped  out  1  single-cycle pulse: a strobe arrived while busy and was ignored.
- ap_req  out  1  downstream request.
- ap_sel  out  8  downstream AP select.
- ap_addr  out  6  {banksel, addr}.
- ap_r_nw  out  1  downstream direction.
- ap_wdata  out  32  downstream write data.
- ap_ack  in  1  downstream completion; sampled only while ap_req is high.
- ap_err  in  1  downstream error; qualified by ap_ack.
- ap_rdata_in  in  32  downstream read data; qualified by ap_ack and ap_r_nw.

Behaviour:
- Reset values: state IDLE, ap_req=0, ap_rdy=1, ap_rdata=0, dp_set_stickyerr=0, dp_ap_dropped=0, ap_sel=0, ap_addr=0, ap_r_nw=0, ap_wdata=0, timeout counter=0, discard flag=0, timeout flag=0.
- Reset asserted mid-access: ap_req drops on the next edge and any in-flight result is lost. The downstream AP logic is reset by the same rst.
- States:
  - IDLE: ap_rdy=1, ap_req=0.
  - BUSY: ap_rdy=0, ap_req=1.
- IDLE -> BUSY on dp_ap_en:
  - dp_ap_r_nw, {dp_apbanksel, dp_ap_addr}, dp_apsel and dp_ap_wdata are captured into the ap_* registers.
  - Strobe at edge N gives ap_req=1 and ap_rdy=0 after edge N, i.e. one cycle of latency.
- In BUSY, ap_sel, ap_addr, ap_r_nw and ap_wdata are held stable, and ap_req stays high until ap_ack is sampled high. Dropping the request early is forbidden.
- BUSY -> IDLE at the edge where ap_ack=1:
  - ap_req=0 and ap_rdy=1 from the next cycle.
  - Read, ap_err=0, discard=0: ap_rdata <= ap_rdata_in.
  - Write, or any ap_err=1: ap_rdata unchanged.
  - ap_err=1 and discard=0: dp_set_stickyerr pulses for one cycle.
  - Clears the timeout counter, discard flag and timeout flag.
- Back-to-back: a dp_ap_en in the first cycle of ap_rdy=1 is accepted, giving a minimum of two cycles between consecutive ap_req rising edges.
- dp_ap_en while BUSY, including the ack cycle itself: the strobe is ignored, dp_ap_dropped pulses for one cycle, and state and captured fields are unchanged.
- Timeout:
  - The counter increments every BUSY cycle without ack and saturates at TIMEOUT_CYCLES.
  - On the cycle it reaches TIMEOUT_CYCLES, dp_set_stickyerr pulses once and the timeout flag is set. The flag prevents a second pulse for this access.
  - The block stays in BUSY, still waiting for ack.
- Abort:
  - dp_ap_abort in BUSY sets the discard flag. ap_req stays high until ack, the result is discarded (no ap_rdata update, no error pulse), then the block returns to IDLE.
  - dp_ap_abort in IDLE: no effect.
  - Abort and ack in the same cycle: discard takes effect, so ap_rdata is not updated and no error pulse is generated.
- Timeout pulse and an ack with ap_err in the same cycle: a single dp_set_stickyerr pulse.
- ap_ack, ap_err and ap_rdata_in are ignored in IDLE.

Test Plan:
- Reset, then IDLE read: dp_ap_en at N with r_nw=1, apsel=0x02, banksel=0xF, addr=3 -> after N: ap_req=1, ap_addr=0x3F, ap_sel=0x02, ap_rdy=0. Ack at N+3 with rdata 0x12345678 -> after N+3: ap_req=0, ap_rdy=1, ap_rdata=0x12345678.
- Write with ap_err: wdata 0xDEADBEEF, ack+err on the 2nd BUSY cycle -> dp_set_stickyerr high for exactly one cycle; ap_rdata unchanged; ap_rdy=1 afterwards.
- Overlap: second dp_ap_en one cycle after the first -> dp_ap_dropped pulses once, captured fields stay those of the first access, and there is a single ap_req episode.
- Timeout: TIMEOUT_CYCLES=4, no ack for 10 cycles -> single dp_set_stickyerr pulse on the 4th BUSY cycle, ap_req held high throughout; a later ack with rdata 0xAAAA5555 updates ap_rdata.
- Abort: read outstanding, dp_ap_abort, then ack with err=1 and rdata 0x11111111 -> no sticky pulse, ap_rdata keeps its old value 0x12345678, ap_rdy=1. Repeat with abort in the same cycle as ack -> same result.
- Mid-access reset: rst asserted while BUSY -> after the edge: ap_req=0, ap_rdy=1, ap_rdata=0; the next dp_ap_en is accepted normally.
